bus_port_fifo: RTL and testbench

- Per-terminal interface FIFO that sits between one device and one port of the bus generator/arbiter (bs_gnrtr_n_rbtr).
- TX path: buffers device packets and presents them to the bus as pndng/D_pop; the bus drains them with pop.
- RX path: captures D_push on push, filters by destination ID, and buffers accepted packets for the device to read.
- One instance per bus terminal; drvrs instances in total.

---
 rtl/bus_port_fifo_pkg.sv | 22 ++
 rtl/bus_port_fifo_if.sv | 30 +++
 rtl/bus_port_fifo_sync_fifo.sv | 61 ++++++
 rtl/bus_port_fifo.sv | 97 +++++++++
 tb/tb_bus_port_fifo.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/bus_port_fifo_pkg.sv
// rtl/bus_port_fifo_pkg.sv - shared constants and helpers for the bus port FIFO
package bus_port_pkg;

  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

  // Widest packet the destination helper accepts; narrower packets are zero-extended.
  localparam int MAX_PKT_W = 64;

  // Bit positions inside the sticky err vector.
  localparam int ERR_TX_OVF = 0;
  localparam int ERR_TX_UDF = 1;
  localparam int ERR_RX_OVF = 2;
  localparam int ERR_RX_ID  = 3;

  // Destination ID lives in the top ID_W bits of a pkt_w-wide packet.
  function automatic logic [ID_W-1:0] get_dest(input logic [MAX_PKT_W-1:0] pkt,
                                               input int unsigned pkt_w);
    return ID_W'(pkt >> (pkt_w - ID_W));
  endfunction

endpackage

// File: rtl/bus_port_fifo_if.sv
// rtl/bus_port_fifo_if.sv - bus-side handshake between a terminal FIFO and the arbiter
interface bus_port_fifo_if #(
  parameter int pckg_sz = 16
);

  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [pckg_sz-1:0] D_push;

  // Arbiter side: sees pending packets, drains with pop, delivers with push.
  modport master (
    input  pndng,
    input  D_pop,
    output pop,
    output push,
    output D_push
  );

  // Terminal side: offers TX head, accepts RX packets.
  modport slave (
    output pndng,
    output D_pop,
    input  pop,
    input  push,
    input  D_push
  );

endinterface

// File: rtl/bus_port_fifo_sync_fifo.sv
// rtl/bus_port_fifo_sync_fifo.sv - show-ahead synchronous FIFO with count-based flags
module bus_port_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    cnt,
  output logic             ovf,
  output logic             udf
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // Flags come from the count so pointer equality never has to be disambiguated.
  always_comb begin
    full  = (cnt == CW'(DEPTH));
    empty = (cnt == '0);
    rd_ok = rd && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    wr_ok = wr && (!full || rd_ok);
    ovf   = wr && !wr_ok;
    udf   = rd && empty;
    rdata = empty ? '0 : mem[rd_ptr];
  end

  // Storage is deliberately left uninitialised; the empty gate hides stale data.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= PW'(wr_ptr + 1'b1);
      if (rd_ok) rd_ptr <= PW'(rd_ptr + 1'b1);
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= CW'(cnt + 1'b1);
        2'b01:   cnt <= CW'(cnt - 1'b1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/bus_port_fifo.sv
// rtl/bus_port_fifo.sv - per-terminal TX/RX FIFO pair with ID filter and sticky errors
module bus_port_fifo
  import bus_port_pkg::*;
#(
  parameter int pckg_sz = 16,
  parameter int depth   = 4,
  parameter int id      = 0,
  localparam int CW = $clog2(depth + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dev_wr,
  input  logic [pckg_sz-1:0] dev_wdata,
  output logic               tx_full,
  output logic [CW-1:0]      tx_cnt,
  input  logic               dev_rd,
  output logic [pckg_sz-1:0] dev_rdata,
  output logic               rx_empty,
  output logic [CW-1:0]      rx_cnt,
  output logic [3:0]         err,
  bus_port_fifo_if.slave     bus
);

  logic               tx_empty;
  logic               tx_ovf;
  logic               tx_udf;
  logic [pckg_sz-1:0] tx_head;
  logic               rx_full;
  logic               rx_ovf;
  logic               rx_udf;
  logic [ID_W-1:0]    dest;
  logic               rx_accept;
  logic               rx_id_drop;
  logic [3:0]         err_set;

  // Reading an empty RX FIFO is harmless, and RX fullness is only seen via the overflow pulse.
  wire unused_ok = &{1'b0, rx_udf, rx_full};

  bus_port_sync_fifo #(
    .WIDTH (pckg_sz),
    .DEPTH (depth)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (reset),
    .wr    (dev_wr),
    .wdata (dev_wdata),
    .rd    (bus.pop),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .cnt   (tx_cnt),
    .ovf   (tx_ovf),
    .udf   (tx_udf)
  );

  bus_port_sync_fifo #(
    .WIDTH (pckg_sz),
    .DEPTH (depth)
  ) u_rx_fifo (
    .clk   (clk),
    .rst_n (reset),
    .wr    (rx_accept),
    .wdata (bus.D_push),
    .rd    (dev_rd),
    .rdata (dev_rdata),
    .full  (rx_full),
    .empty (rx_empty),
    .cnt   (rx_cnt),
    .ovf   (rx_ovf),
    .udf   (rx_udf)
  );

  // Destination filter: keep packets addressed to this terminal or broadcast.
  always_comb begin
    dest       = get_dest(MAX_PKT_W'(bus.D_push), pckg_sz);
    rx_accept  = bus.push && ((dest == ID_W'(id)) || (dest == BROADCAST_ID));
    rx_id_drop = bus.push && !rx_accept;
    bus.pndng  = !tx_empty;
    bus.D_pop  = tx_head;
  end

  // Collect this cycle's error events into their err bit positions.
  always_comb begin
    err_set             = '0;
    err_set[ERR_TX_OVF] = tx_ovf;
    err_set[ERR_TX_UDF] = tx_udf;
    err_set[ERR_RX_OVF] = rx_ovf;
    err_set[ERR_RX_ID]  = rx_id_drop;
  end

  // Error flags accumulate until the next reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err <= '0;
    else        err <= err | err_set;
  end

endmodule

// File: tb/tb_bus_port_fifo.sv
// tb/tb_bus_port_fifo.sv - directed self-checking bench for bus_port_fifo
module tb_bus_port_fifo;

  logic        clk;
  logic        reset;
  logic        dev_wr;
  logic [15:0] dev_wdata;
  logic        tx_full;
  logic [2:0]  tx_cnt;
  logic        dev_rd;
  logic [15:0] dev_rdata;
  logic        rx_empty;
  logic [2:0]  rx_cnt;
  logic [3:0]  err;

  int vectors;
  int miscompares;

  bus_port_fifo_if #(.pckg_sz(16)) bus_if ();

  bus_port_fifo #(
    .pckg_sz (16),
    .depth   (4),
    .id      (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dev_wr    (dev_wr),
    .dev_wdata (dev_wdata),
    .tx_full   (tx_full),
    .tx_cnt    (tx_cnt),
    .dev_rd    (dev_rd),
    .dev_rdata (dev_rdata),
    .rx_empty  (rx_empty),
    .rx_cnt    (rx_cnt),
    .err       (err),
    .bus       (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs and samples both sit 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dev_wr      = 1'b0;
    dev_wdata   = '0;
    dev_rd      = 1'b0;
    bus_if.pop  = 1'b0;
    bus_if.push = 1'b0;
    bus_if.D_push = '0;
  endtask

  task automatic tx_write(input logic [15:0] d);
    dev_wr = 1'b1; dev_wdata = d;
    tick();
    idle();
  endtask

  task automatic bus_push(input logic [15:0] d);
    bus_if.push = 1'b1; bus_if.D_push = d;
    tick();
    idle();
  endtask

  task automatic tx_pop_expect(input string tag, input logic [15:0] exp);
    check(tag, bus_if.D_pop, exp);
    bus_if.pop = 1'b1;
    tick();
    idle();
  endtask

  task automatic rx_read_expect(input string tag, input logic [15:0] exp);
    check(tag, dev_rdata, exp);
    dev_rd = 1'b1;
    tick();
    idle();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_pndng",    {15'd0, bus_if.pndng}, 16'd0);
    check("rst_d_pop",    bus_if.D_pop, 16'd0);
    check("rst_tx_full",  {15'd0, tx_full}, 16'd0);
    check("rst_rx_empty", {15'd0, rx_empty}, 16'd1);
    check("rst_err",      {12'd0, err}, 16'd0);
    check("rst_rdata",    dev_rdata, 16'd0);
    check("rst_cnts",     {10'd0, tx_cnt, rx_cnt}, 16'd0);
    reset = 1'b1;
    tick();

    // Single write then pop
    tx_write(16'h02A1);
    check("s1_pndng",  {15'd0, bus_if.pndng}, 16'd1);
    check("s1_tx_cnt", {13'd0, tx_cnt}, 16'd1);
    tx_pop_expect("s1_d_pop", 16'h02A1);
    check("s1_pndng_after", {15'd0, bus_if.pndng}, 16'd0);
    check("s1_d_pop_after", bus_if.D_pop, 16'd0);

    // Overfill TX: fifth write dropped
    for (int i = 1; i <= 4; i++) tx_write(16'h0100 + 16'(i));
    check("s2_full",  {15'd0, tx_full}, 16'd1);
    check("s2_err_before", {12'd0, err}, 16'h0);
    tx_write(16'h0105);
    check("s2_cnt",   {13'd0, tx_cnt}, 16'd4);
    check("s2_err",   {12'd0, err}, 16'h1);
    for (int i = 1; i <= 4; i++) tx_pop_expect("s2_drain", 16'h0100 + 16'(i));
    check("s2_empty", {15'd0, bus_if.pndng}, 16'd0);

    // Write and pop together on a full TX
    for (int i = 1; i <= 4; i++) tx_write(16'h0100 + 16'(i));
    dev_wr = 1'b1; dev_wdata = 16'h0199; bus_if.pop = 1'b1;
    tick();
    idle();
    check("s3_cnt", {13'd0, tx_cnt}, 16'd4);
    check("s3_err", {12'd0, err}, 16'h1);
    tx_pop_expect("s3_drain0", 16'h0102);
    tx_pop_expect("s3_drain1", 16'h0103);
    tx_pop_expect("s3_drain2", 16'h0104);
    tx_pop_expect("s3_drain3", 16'h0199);

    // RX ID filter
    bus_push(16'h02BB);
    bus_push(16'hFFCC);
    bus_push(16'h03DD);
    check("s4_rx_cnt", {13'd0, rx_cnt}, 16'd2);
    check("s4_err",    {12'd0, err}, 16'h9);
    rx_read_expect("s4_rd0", 16'h02BB);
    rx_read_expect("s4_rd1", 16'hFFCC);
    check("s4_rx_empty", {15'd0, rx_empty}, 16'd1);

    // Underflows
    bus_if.pop = 1'b1;
    tick();
    idle();
    check("s5_udf_err", {12'd0, err}, 16'hB);
    check("s5_tx_cnt",  {13'd0, tx_cnt}, 16'd0);
    dev_rd = 1'b1;
    tick();
    idle();
    check("s5_rd_empty_err", {12'd0, err}, 16'hB);

    // Write plus pop on empty TX: write kept, pop flagged (already sticky)
    dev_wr = 1'b1; dev_wdata = 16'h0277; bus_if.pop = 1'b1;
    tick();
    idle();
    check("s5b_cnt", {13'd0, tx_cnt}, 16'd1);
    tx_pop_expect("s5b_head", 16'h0277);

    // RX overflow, then push with read on full RX
    for (int i = 1; i <= 4; i++) bus_push(16'h0200 + 16'(i));
    check("s6_rx_cnt", {13'd0, rx_cnt}, 16'd4);
    bus_push(16'h0205);
    check("s6_rx_ovf", {12'd0, err}, 16'hF);
    check("s6_rx_cnt2", {13'd0, rx_cnt}, 16'd4);
    bus_if.push = 1'b1; bus_if.D_push = 16'h0206; dev_rd = 1'b1;
    tick();
    idle();
    check("s6_rx_cnt3", {13'd0, rx_cnt}, 16'd4);
    rx_read_expect("s6_rd0", 16'h0202);
    rx_read_expect("s6_rd1", 16'h0203);
    rx_read_expect("s6_rd2", 16'h0204);
    rx_read_expect("s6_rd3", 16'h0206);

    // Push with read on empty RX: packet stored, read ignored
    bus_if.push = 1'b1; bus_if.D_push = 16'hFF11; dev_rd = 1'b1;
    tick();
    idle();
    check("s7_rx_cnt", {13'd0, rx_cnt}, 16'd1);
    rx_read_expect("s7_rd", 16'hFF11);

    // Mid-cycle reset with traffic queued
    for (int i = 1; i <= 3; i++) tx_write(16'h0300 + 16'(i));
    bus_push(16'h0244);
    bus_push(16'h0255);
    check("s8_pre_tx", {13'd0, tx_cnt}, 16'd3);
    check("s8_pre_rx", {13'd0, rx_cnt}, 16'd2);
    #2;
    reset = 1'b0;
    #1;
    check("s8_pndng",    {15'd0, bus_if.pndng}, 16'd0);
    check("s8_rx_empty", {15'd0, rx_empty}, 16'd1);
    check("s8_err",      {12'd0, err}, 16'd0);
    check("s8_outs",     bus_if.D_pop | dev_rdata, 16'd0);
    tick();
    reset = 1'b1;
    tick();
    tx_write(16'h02A1);
    check("s9_pndng",  {15'd0, bus_if.pndng}, 16'd1);
    check("s9_tx_cnt", {13'd0, tx_cnt}, 16'd1);
    tx_pop_expect("s9_d_pop", 16'h02A1);
    check("s9_empty",  {15'd0, bus_if.pndng}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
